// File: rtl/jtframe_db15_pkg.sv
// Shared definitions for the DB15 joystick responder.
//   - Bit positions of each control inside one player's word.
//   - Default number of bits per player.
//   - State encoding of the responder FSM.
package jtframe_db15_pkg;

  localparam int UP     = 0;
  localparam int DOWN   = 1;
  localparam int LEFT   = 2;
  localparam int RIGHT  = 3;
  localparam int B1     = 4;
  localparam int B2     = 5;
  localparam int B3     = 6;
  localparam int B4     = 7;
  localparam int B5     = 8;
  localparam int B6     = 9;
  localparam int START  = 10;
  localparam int COIN   = 11;

  localparam int PW_DEF = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } db15_st_t;

endpackage

// File: rtl/jtframe_db15_edge.sv
// Synchronizer for one asynchronous reader line.
// Ports:
//   clk    in  system clock
//   rst_n  in  async active-low reset; all stages reset to RST_VAL
//   din    in  raw asynchronous input
//   sig    out RISE=0: synchronized level
//              RISE=1: one-cycle pulse on a synchronized rising edge
// SYNC must be at least 2.
module jtframe_db15_edge
  import jtframe_db15_pkg::*;
#(
  parameter int   SYNC    = 2,
  parameter logic RST_VAL = 1'b0,
  parameter logic RISE    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sig
);

  logic [SYNC-1:0] sync_q, sync_d;
  logic            prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC-2:0], din};
    prev_d = sync_q[SYNC-1];
  end

  // p0: synchronizer chain plus one history flop for edge detection.
  // prev resets to the same value as the chain so no edge is seen at reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  always_comb begin
    if (RISE) sig = sync_q[SYNC-1] & ~prev_q;
    else      sig = sync_q[SYNC-1];
  end

endmodule

// File: rtl/jtframe_db15_responder.sv
// Device side of the serial DB15 joystick link: a parallel-in/serial-out
// shift chain that latches both players on a load pulse and shifts them out
// MSB-first, one bit per JOY_CLK rising edge.
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   joy1, joy2   player controls, active-high {coin,start,b6..b1,right,left,down,up}
//   JOY_LOAD     active-low parallel load from the reader (asynchronous)
//   JOY_CLK      shift clock from the reader (asynchronous, rising edge)
//   JOY_DATA     serial data, active-low buttons, straight from a flop
//   busy         high while a frame is being shifted
//   frame_done   one-cycle pulse when the last of the 2*PW bits is shifted
//   overrun      sticky: shift edges arrived after the frame completed
module jtframe_db15_responder
  import jtframe_db15_pkg::*;
#(
  parameter int   PW   = PW_DEF,
  parameter int   SYNC = 2,
  parameter logic FILL = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] joy1,
  input  logic [PW-1:0] joy2,
  input  logic          JOY_LOAD,
  input  logic          JOY_CLK,
  output logic          JOY_DATA,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun
);

  localparam int NB = 2 * PW;
  localparam int CW = $clog2(NB + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NB);

  // Shift counter never wraps: it holds at NB once the frame is complete.
  function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] c);
    if (c == CNT_FULL) return c;
    return c + CW'(1);
  endfunction

  logic ld_lvl;
  logic ld_low;
  logic clk_rise;

  jtframe_db15_edge #(
    .SYNC    (SYNC),
    .RST_VAL (1'b1),
    .RISE    (1'b0)
  ) u_load (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (JOY_LOAD),
    .sig   (ld_lvl)
  );

  jtframe_db15_edge #(
    .SYNC    (SYNC),
    .RST_VAL (1'b0),
    .RISE    (1'b1)
  ) u_clk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (JOY_CLK),
    .sig   (clk_rise)
  );

  assign ld_low = ~ld_lvl;

  db15_st_t        st_q, st_d;
  logic [NB-1:0]   sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            frame_done_q, frame_done_d;
  logic            overrun_q, overrun_d;

  // p1: FSM state, shift chain, counter and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= IDLE;
      sr_q         <= {NB{FILL}};
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      st_q         <= st_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // A synced load has priority over everything, including a shift edge
  // arriving in the same cycle.
  always_comb begin
    st_d = st_q;
    if (ld_low) begin
      st_d = LOAD;
    end else begin
      case (st_q)
        IDLE:    st_d = IDLE;
        LOAD:    st_d = SHIFT;
        SHIFT:   if (clk_rise && cnt_q == CNT_LAST) st_d = DONE;
        DONE:    st_d = DONE;
        default: st_d = IDLE;
      endcase
    end
  end

  // Datapath: the chain is reloaded on every cycle the load is held low,
  // so the controls are sampled at the moment the reader lets go.
  always_comb begin
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    if (ld_low) begin
      sr_d      = ~{joy1, joy2};
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else if (clk_rise) begin
      case (st_q)
        SHIFT: begin
          sr_d         = {sr_q[NB-2:0], FILL};
          cnt_d        = cnt_sat_inc(cnt_q);
          frame_done_d = (cnt_q == CNT_LAST);
        end
        DONE: begin
          sr_d      = {sr_q[NB-2:0], FILL};
          cnt_d     = cnt_sat_inc(cnt_q);
          overrun_d = 1'b1;
        end
        default: begin
          sr_d = sr_q;
        end
      endcase
    end
  end

  always_comb begin
    busy       = (st_q == SHIFT);
    JOY_DATA   = sr_q[NB-1];
    frame_done = frame_done_q;
    overrun    = overrun_q;
  end

endmodule

// File: tb/tb_jtframe_db15_responder.sv
module tb_jtframe_db15_responder;

  localparam int PW = 12;
  localparam int NB = 2 * PW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] joy1 = '0;
  logic [PW-1:0] joy2 = '0;
  logic          JOY_LOAD = 1'b1;
  logic          JOY_CLK = 1'b0;
  logic          JOY_DATA, busy, frame_done, overrun;
  logic          data3, busy3, fd3, ovr3;

  always #5 clk = ~clk;

  jtframe_db15_responder #(.PW(PW), .SYNC(2), .FILL(1'b1)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .joy1       (joy1),
    .joy2       (joy2),
    .JOY_LOAD   (JOY_LOAD),
    .JOY_CLK    (JOY_CLK),
    .JOY_DATA   (JOY_DATA),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  jtframe_db15_responder #(.PW(PW), .SYNC(3), .FILL(1'b1)) u_dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .joy1       (joy1),
    .joy2       (joy2),
    .JOY_LOAD   (JOY_LOAD),
    .JOY_CLK    (JOY_CLK),
    .JOY_DATA   (data3),
    .busy       (busy3),
    .frame_done (fd3),
    .overrun    (ovr3)
  );

  typedef struct {
    logic [PW-1:0] j1;
    logic [PW-1:0] j2;
    logic [NB-1:0] stream;
  } vec_t;

  vec_t          tbl [6];
  int            n_chk = 0;
  int            n_pass = 0;
  int            fd_cnt = 0;
  int            fd_base;
  int            lat2, lat3;
  logic [NB-1:0] model_sr = '1;
  logic          exp_q [$];

  always @(negedge clk) if (frame_done) fd_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, checks %0d", n_chk);
    $fatal(1);
  end

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [NB-1:0] exp_sr);
    JOY_LOAD = 1'b0;
    tick(4);
    model_sr = exp_sr;
    JOY_LOAD = 1'b1;
    tick(4);
  endtask

  task automatic pulse_chk(input string name);
    model_sr = {model_sr[NB-2:0], 1'b1};
    exp_q.push_back(model_sr[NB-1]);
    JOY_CLK = 1'b1;
    tick(4);
    JOY_CLK = 1'b0;
    tick(4);
    check1(name, JOY_DATA, exp_q.pop_front());
  endtask

  initial begin
    tbl[0] = '{12'h000, 12'h000, 24'hFFFFFF};
    tbl[1] = '{12'hFFF, 12'hFFF, 24'h000000};
    tbl[2] = '{12'h0A5, 12'hF0F, 24'hF5A0F0};
    tbl[3] = '{12'h123, 12'h456, 24'hEDCBA9};
    tbl[4] = '{12'h400, 12'h00C, 24'hBFFFF3};
    tbl[5] = '{12'h801, 12'h010, 24'h7FEFEF};

    // Reset state
    tick(3);
    check1("rst_data", JOY_DATA, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", frame_done, 1'b0);
    check1("rst_ovr", overrun, 1'b0);
    check1("rst_data_s3", data3, 1'b1);
    check1("rst_busy_s3", busy3, 1'b0);
    check1("rst_done_s3", fd3, 1'b0);
    check1("rst_ovr_s3", ovr3, 1'b0);
    rst_n = 1'b1;
    tick(2);
    model_sr = '1;
    for (int k = 0; k < 5; k++) pulse_chk($sformatf("idle_clk%0d", k));
    check1("idle_busy", busy, 1'b0);

    // Full frames from the vector table; controls scrambled mid-frame
    for (int i = 0; i < 6; i++) begin
      fd_base = fd_cnt;
      joy1 = tbl[i].j1;
      joy2 = tbl[i].j2;
      do_load(tbl[i].stream);
      check1($sformatf("busy_v%0d", i), busy, 1'b1);
      check1($sformatf("bit0_v%0d", i), JOY_DATA, model_sr[NB-1]);
      for (int k = 0; k < NB; k++) begin
        if (k == 5) begin
          joy1 = PW'($urandom);
          joy2 = PW'($urandom);
        end
        pulse_chk($sformatf("bit%0d_v%0d", k + 1, i));
      end
      checkn($sformatf("fdone_v%0d", i), fd_cnt - fd_base, 1);
      check1($sformatf("idle_after_v%0d", i), busy, 1'b0);
      check1($sformatf("no_ovr_v%0d", i), overrun, 1'b0);
    end

    // Overrun after the 801/010 frame
    fd_base = fd_cnt;
    pulse_chk("ovr_clk0");
    pulse_chk("ovr_clk1");
    check1("ovr_set", overrun, 1'b1);
    checkn("ovr_no_extra_done", fd_cnt - fd_base, 0);
    joy1 = 12'h0F0;
    joy2 = 12'h333;
    do_load(~{joy1, joy2});
    check1("ovr_cleared", overrun, 1'b0);

    // Abort after 7 clocks, then reload fresh controls
    fd_base = fd_cnt;
    for (int k = 0; k < 7; k++) pulse_chk($sformatf("abort_bit%0d", k + 1));
    joy1 = 12'hA5A;
    joy2 = 12'h5A5;
    do_load(~{joy1, joy2});
    checkn("abort_no_done", fd_cnt - fd_base, 0);
    check1("abort_bit0", JOY_DATA, model_sr[NB-1]);
    for (int k = 0; k < NB; k++) pulse_chk($sformatf("reload_bit%0d", k + 1));
    checkn("reload_done", fd_cnt - fd_base, 1);

    // Load fall and shift rise landing in the same cycle
    joy1 = 12'hFFF;
    joy2 = 12'h000;
    do_load(~{joy1, joy2});
    for (int k = 0; k < 3; k++) pulse_chk($sformatf("pre_coll_bit%0d", k + 1));
    joy1 = 12'h7FF;
    joy2 = 12'h000;
    JOY_LOAD = 1'b0;
    JOY_CLK  = 1'b1;
    tick(4);
    model_sr = ~{joy1, joy2};
    JOY_LOAD = 1'b1;
    JOY_CLK  = 1'b0;
    tick(4);
    fd_base = fd_cnt;
    check1("coll_bit0", JOY_DATA, model_sr[NB-1]);
    for (int k = 0; k < NB - 1; k++) pulse_chk($sformatf("coll_bit%0d", k + 1));
    checkn("coll_cnt_not_early", fd_cnt - fd_base, 0);
    pulse_chk("coll_bit24");
    checkn("coll_done", fd_cnt - fd_base, 1);

    // Pin-to-data latency on both synchronizer depths
    joy1 = 12'h800;
    joy2 = 12'h000;
    do_load(~{joy1, joy2});
    check1("lat_pre", JOY_DATA, 1'b0);
    JOY_CLK = 1'b1;
    lat2 = -1;
    lat3 = -1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      if (lat2 < 0 && JOY_DATA !== 1'b0) lat2 = e;
      if (lat3 < 0 && data3 !== 1'b0) lat3 = e;
    end
    checkn("latency_sync2", lat2, 3);
    checkn("latency_sync3", lat3, 4);
    JOY_CLK = 1'b0;
    tick(4);

    // Asynchronous reset in the middle of a frame
    joy1 = 12'hFFF;
    joy2 = 12'hFFF;
    do_load(~{joy1, joy2});
    for (int k = 0; k < 5; k++) pulse_chk($sformatf("mid_bit%0d", k + 1));
    fd_base = fd_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check1("mid_rst_data", JOY_DATA, 1'b1);
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_done", frame_done, 1'b0);
    check1("mid_rst_ovr", overrun, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    model_sr = '1;
    for (int k = 0; k < 3; k++) pulse_chk($sformatf("post_rst_clk%0d", k));
    checkn("mid_rst_no_done", fd_cnt - fd_base, 0);
    check1("post_rst_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
